// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory port arbiter.
// Holds the arbiter state encoding, the "no access" code and lane selects.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_DONE  = 3'd5
  } arb_state_t;

  localparam logic [2:0] MEM_NONE = 3'b000;
  localparam logic       LANE0    = 1'b0;
  localparam logic       LANE1    = 1'b1;

  function automatic logic lane_need(input logic [2:0] rd_code, input logic [2:0] wr_code);
    return (rd_code != MEM_NONE) || (wr_code != MEM_NONE);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments while enabled, sticks at all-ones.
// Used for the stall-cycle performance counter of the port arbiter.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = &r_count;
  assign o_count  = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises the two lanes' MEM-stage accesses onto the single data-memory port,
// lane 0 first, stalling the pipeline until the whole pair has completed.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      MemReadM_0,
  input  logic [2:0]      MemWriteM_0,
  input  logic [XLEN-1:0] AluResultM_0,
  input  logic [XLEN-1:0] WriteDataM_0,
  input  logic [2:0]      MemReadM_1,
  input  logic [2:0]      MemWriteM_1,
  input  logic [XLEN-1:0] AluResultM_1,
  input  logic [XLEN-1:0] WriteDataM_1,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [2:0]      dmem_size,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] ReadDataM_0,
  output logic [XLEN-1:0] ReadDataM_1,
  output logic            StallMem,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [2:0]      dbg_state
);

  arb_state_t r_state, w_next_state, w_after_lane0;
  logic            w_need_0, w_need_1;
  logic            w_we_0, w_we_1;
  logic [2:0]      w_size_0, w_size_1;
  logic            w_sel;
  logic [XLEN-1:0] r_rdata_0, r_rdata_1;

  // A lane with both codes set is treated as a store: the write code wins.
  assign w_need_0  = lane_need(MemReadM_0, MemWriteM_0);
  assign w_need_1  = lane_need(MemReadM_1, MemWriteM_1);
  assign w_we_0    = (MemWriteM_0 != MEM_NONE);
  assign w_we_1    = (MemWriteM_1 != MEM_NONE);
  assign w_size_0  = w_we_0 ? MemWriteM_0 : MemReadM_0;
  assign w_size_1  = w_we_1 ? MemWriteM_1 : MemReadM_1;
  assign w_sel     = (r_state == ST_REQ1) ? LANE1 : LANE0;
  assign w_after_lane0 = w_need_1 ? ST_REQ1 : ST_DONE;
  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_need_0)      w_next_state = ST_REQ0;
        else if (w_need_1) w_next_state = ST_REQ1;
      end
      ST_REQ0: begin
        if (dmem_gnt) w_next_state = w_we_0 ? w_after_lane0 : ST_WAIT0;
      end
      ST_WAIT0: begin
        if (dmem_rvalid) w_next_state = w_after_lane0;
      end
      ST_REQ1: begin
        if (dmem_gnt) w_next_state = w_we_1 ? ST_DONE : ST_WAIT1;
      end
      ST_WAIT1: begin
        if (dmem_rvalid) w_next_state = ST_DONE;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Request fields come straight from the stalled EX/MEM outputs, so they
  // stay stable for as long as the request waits for a grant.
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_size  = MEM_NONE;
    dmem_addr  = '0;
    dmem_wdata = '0;
    StallMem   = 1'b1;
    case (r_state)
      ST_IDLE: StallMem = w_need_0 | w_need_1;
      ST_DONE: StallMem = 1'b0;
      default: StallMem = 1'b1;
    endcase
    if (r_state == ST_REQ0 || r_state == ST_REQ1) begin
      dmem_req = 1'b1;
      if (w_sel == LANE1) begin
        dmem_we    = w_we_1;
        dmem_size  = w_size_1;
        dmem_addr  = AluResultM_1;
        dmem_wdata = WriteDataM_1;
      end else begin
        dmem_we    = w_we_0;
        dmem_size  = w_size_0;
        dmem_addr  = AluResultM_0;
        dmem_wdata = WriteDataM_0;
      end
    end
  end

  // Load data is only accepted while that lane is waiting; stray rvalid is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata_0 <= '0;
      r_rdata_1 <= '0;
    end else begin
      if (r_state == ST_WAIT0 && dmem_rvalid) r_rdata_0 <= dmem_rdata;
      if (r_state == ST_WAIT1 && dmem_rvalid) r_rdata_1 <= dmem_rdata;
    end
  end

  assign ReadDataM_0 = r_rdata_0;
  assign ReadDataM_1 = r_rdata_1;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (StallMem),
    .o_count (stall_cycles)
  );

`ifndef SYNTHESIS
  a_lane0_legal: assert property (@(posedge clk) disable iff (rst)
    !((MemReadM_0 != MEM_NONE) && (MemWriteM_0 != MEM_NONE)));
  a_lane1_legal: assert property (@(posedge clk) disable iff (rst)
    !((MemReadM_1 != MEM_NONE) && (MemWriteM_1 != MEM_NONE)));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// sequences for memory ordering, reset mid-load and counter saturation.
module tb_mem_port_arbiter;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic            clk, rst;
  logic [2:0]      mr0, mw0, mr1, mw1;
  logic [31:0]     a0, wd0, a1, wd1;
  logic            dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [2:0]      dmem_size;
  logic [31:0]     dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0]     rd0, rd1;
  logic            stall;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      state;

  logic            t_gnt, t_rvalid, model_en;
  logic [31:0]     t_rdata;
  logic            m_rvalid;
  logic [31:0]     m_rdata;
  logic [31:0]     mem [0:255];
  logic [32:0]     obs_q[$];
  logic [32:0]     exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  assign dmem_gnt    = model_en ? dmem_req : t_gnt;
  assign dmem_rvalid = model_en ? m_rvalid : t_rvalid;
  assign dmem_rdata  = model_en ? m_rdata  : t_rdata;

  mem_port_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .MemReadM_0(mr0), .MemWriteM_0(mw0), .AluResultM_0(a0), .WriteDataM_0(wd0),
    .MemReadM_1(mr1), .MemWriteM_1(mw1), .AluResultM_1(a1), .WriteDataM_1(wd1),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .ReadDataM_0(rd0), .ReadDataM_1(rd1), .StallMem(stall),
    .stall_cycles(cnt), .dbg_state(state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Memory model: grants immediately, load data one cycle after grant.
  always @(posedge clk) begin
    m_rvalid <= 1'b0;
    if (model_en && dmem_req && dmem_gnt) begin
      obs_q.push_back({dmem_we, dmem_addr});
      if (dmem_we) begin
        mem[dmem_addr[9:2]] <= dmem_wdata;
      end else begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem[dmem_addr[9:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_lanes(input logic [2:0] r0, input logic [2:0] w0, input logic [31:0] ad0,
                           input logic [31:0] d0, input logic [2:0] r1, input logic [2:0] w1,
                           input logic [31:0] ad1, input logic [31:0] d1);
    mr0 = r0; mw0 = w0; a0 = ad0; wd0 = d0;
    mr1 = r1; mw1 = w1; a1 = ad1; wd1 = d1;
  endtask

  task automatic do_reset;
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    t_gnt = 0; t_rvalid = 0; t_rdata = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  mr0, mw0; logic [31:0] a0, wd0;
    logic [2:0]  mr1, mw1; logic [31:0] a1, wd1;
    logic        gnt, rv;  logic [31:0] rdata;
    logic        e_req, e_we; logic [2:0] e_size; logic [31:0] e_addr, e_wdata;
    logic        e_stall; logic [2:0] e_state; logic [31:0] e_rd0, e_rd1; logic [3:0] e_cnt;
  } vec_t;

  vec_t vt[18];

  initial begin
    logic [32:0] o, e;
    int cyc;

    rst = 1'b1; model_en = 1'b0;
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    t_gnt = 0; t_rvalid = 0; t_rdata = 0;

    // Columns: lane0{rd,wr,addr,wdata} lane1{rd,wr,addr,wdata} mem{gnt,rvalid,rdata}
    //          expect{req,we,size,addr,wdata,stall,state,rd0,rd1,cnt}
    vt[0]  = '{2,0,'h100,0, 0,0,0,0, 0,0,0,              0,0,0,0,0,         1,0,0,0,0};
    vt[1]  = '{2,0,'h100,0, 0,0,0,0, 1,0,0,              1,0,2,'h100,0,     1,1,0,0,1};
    vt[2]  = '{2,0,'h100,0, 0,0,0,0, 0,1,'hDEADBEEF,     0,0,0,0,0,         1,2,0,0,2};
    vt[3]  = '{2,0,'h100,0, 0,0,0,0, 0,0,0,              0,0,0,0,0,         0,5,'hDEADBEEF,0,3};
    vt[4]  = '{0,0,0,0,     0,0,0,0, 0,0,0,              0,0,0,0,0,         0,0,'hDEADBEEF,0,3};
    vt[5]  = '{0,1,'h204,'hAB, 4,0,'h300,0, 0,0,0,       0,0,0,0,0,         1,0,'hDEADBEEF,0,3};
    vt[6]  = '{0,1,'h204,'hAB, 4,0,'h300,0, 0,0,0,       1,1,1,'h204,'hAB,  1,1,'hDEADBEEF,0,4};
    vt[7]  = '{0,1,'h204,'hAB, 4,0,'h300,0, 1,0,0,       1,1,1,'h204,'hAB,  1,1,'hDEADBEEF,0,5};
    vt[8]  = '{0,1,'h204,'hAB, 4,0,'h300,0, 0,1,'h11,    1,0,4,'h300,0,     1,3,'hDEADBEEF,0,6};
    vt[9]  = '{0,1,'h204,'hAB, 4,0,'h300,0, 1,0,0,       1,0,4,'h300,0,     1,3,'hDEADBEEF,0,7};
    vt[10] = '{0,1,'h204,'hAB, 4,0,'h300,0, 0,0,0,       0,0,0,0,0,         1,4,'hDEADBEEF,0,8};
    vt[11] = '{0,1,'h204,'hAB, 4,0,'h300,0, 0,1,'h77,    0,0,0,0,0,         1,4,'hDEADBEEF,0,9};
    vt[12] = '{0,1,'h204,'hAB, 4,0,'h300,0, 0,0,0,       0,0,0,0,0,         0,5,'hDEADBEEF,'h77,10};
    vt[13] = '{0,0,0,0,     0,0,0,0, 0,0,0,              0,0,0,0,0,         0,0,'hDEADBEEF,'h77,10};
    vt[14] = '{0,0,0,0, 0,2,'h400,'hCAFE, 0,0,0,         0,0,0,0,0,         1,0,'hDEADBEEF,'h77,10};
    vt[15] = '{0,0,0,0, 0,2,'h400,'hCAFE, 1,0,0,         1,1,2,'h400,'hCAFE,1,3,'hDEADBEEF,'h77,11};
    vt[16] = '{0,0,0,0, 0,2,'h400,'hCAFE, 0,0,0,         0,0,0,0,0,         0,5,'hDEADBEEF,'h77,12};
    vt[17] = '{0,0,0,0,     0,0,0,0, 0,0,0,              0,0,0,0,0,         0,0,'hDEADBEEF,'h77,12};

    // Reset values
    #2;
    chk("rst_req", dmem_req, 0);     chk("rst_we", dmem_we, 0);
    chk("rst_size", dmem_size, 0);   chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0); chk("rst_rd0", rd0, 0);
    chk("rst_rd1", rd1, 0);          chk("rst_cnt", cnt, 0);
    chk("rst_state", state, 0);      chk("rst_stall", stall, 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle lanes for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      chk("idle_req", dmem_req, 0); chk("idle_stall", stall, 0); chk("idle_cnt", cnt, 0);
    end

    // Per-cycle vector table
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      set_lanes(vt[i].mr0, vt[i].mw0, vt[i].a0, vt[i].wd0, vt[i].mr1, vt[i].mw1, vt[i].a1, vt[i].wd1);
      t_gnt = vt[i].gnt; t_rvalid = vt[i].rv; t_rdata = vt[i].rdata;
      #2;
      chk($sformatf("v%0d_req", i),   dmem_req,   vt[i].e_req);
      chk($sformatf("v%0d_we", i),    dmem_we,    vt[i].e_we);
      chk($sformatf("v%0d_size", i),  dmem_size,  vt[i].e_size);
      chk($sformatf("v%0d_addr", i),  dmem_addr,  vt[i].e_addr);
      chk($sformatf("v%0d_wdata", i), dmem_wdata, vt[i].e_wdata);
      chk($sformatf("v%0d_stall", i), stall,      vt[i].e_stall);
      chk($sformatf("v%0d_state", i), state,      vt[i].e_state);
      chk($sformatf("v%0d_rd0", i),   rd0,        vt[i].e_rd0);
      chk($sformatf("v%0d_rd1", i),   rd1,        vt[i].e_rd1);
      chk($sformatf("v%0d_cnt", i),   cnt,        vt[i].e_cnt);
    end

    // Store lane 0 then load lane 1 from the same address through the memory model
    do_reset();
    model_en = 1'b1;
    exp_q.push_back({1'b1, 32'h200});
    exp_q.push_back({1'b0, 32'h200});
    @(negedge clk);
    set_lanes(0, 3'b010, 32'h200, 32'h55, 3'b010, 0, 32'h200, 0);
    #2;
    cyc = 0;
    while (state !== 3'd5 && cyc < 20) begin
      chk("mm_stall_held", stall, 1);
      @(negedge clk); #2;
      cyc++;
    end
    chk("mm_done_reached", state, 5);
    chk("mm_stall_done", stall, 0);
    chk("mm_rd1", rd1, 32'h55);
    chk("mm_cnt", cnt, 4);
    chk("mm_order_len", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk("mm_order_we", o[32], e[32]);
      chk("mm_order_addr", o[31:0], e[31:0]);
    end
    @(negedge clk);
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    model_en = 1'b0;

    // Reset while waiting for lane-0 load data, then a late rvalid
    do_reset();
    @(negedge clk);
    set_lanes(3'b010, 0, 32'h100, 0, 0, 0, 0, 0);
    #2;
    @(negedge clk); t_gnt = 1; #2;
    chk("rw_req0", state, 1);
    @(negedge clk); t_gnt = 0; #2;
    chk("rw_wait0", state, 2);
    rst = 1'b1; #1;
    chk("rw_rst_req", dmem_req, 0);
    chk("rw_rst_state", state, 0);
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); t_rvalid = 1; t_rdata = 32'h99; #2;
    @(negedge clk); t_rvalid = 0; #2;
    chk("rw_late_rd0", rd0, 0);
    chk("rw_late_state", state, 0);
    chk("rw_late_req", dmem_req, 0);

    // Lane-1 store with grant withheld: stable request and counter saturation
    do_reset();
    @(negedge clk);
    set_lanes(0, 0, 0, 0, 0, 3'b010, 32'h500, 32'h1234);
    #2;
    chk("sat_idle_state", state, 0);
    chk("sat_idle_cnt", cnt, 0);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk); #2;
      chk("sat_state", state, 3);
      chk("sat_cnt", cnt, (k < 15) ? k : 15);
      if (k <= 4) begin
        chk("hold_req", dmem_req, 1);          chk("hold_we", dmem_we, 1);
        chk("hold_size", dmem_size, 3'b010);   chk("hold_addr", dmem_addr, 32'h500);
        chk("hold_wdata", dmem_wdata, 32'h1234);
      end
    end
    @(negedge clk); t_gnt = 1; #2;
    chk("sat_gnt_state", state, 3);
    @(negedge clk); t_gnt = 0; #2;
    chk("sat_done_state", state, 5);
    chk("sat_done_stall", stall, 0);
    chk("sat_done_cnt", cnt, 15);
    @(negedge clk);
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("sat_final_cnt", cnt, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
